word_storage_pingpong_ctrl: RTL and testbench

- Sequences two `word_storage` instances (bank 0, bank 1) as a ping-pong buffer between the packet-side byte writer and the word-consuming datapath.
- Assigns write addresses, latches per-bank word length, issues `set_full` and `set_empty`, and streams stored words out in arrival order through a valid/ready byte interface.
- Either bank may be written while the other is being read.

---
 rtl/word_storage_pingpong_ctrl.sv | 175 +++++++++++++++++
 tb/tb_word_storage_pingpong_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_storage_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// word_storage_pingpong_ctrl
//
// Ping-pong sequencer for two word_storage banks. The byte writer fills the
// bank selected by wr_sel; closing a word marks that bank full, latches its
// length and flips wr_sel. The reader streams the bank selected by rd_sel
// out over a valid/ready byte interface and frees it with set_empty once the
// last beat is accepted. Both pointers flip in the same order, so words leave
// in the order they were closed.
//
// Ports
//   CLK, rst                       clock, synchronous active-high reset
//   in_din/in_wr_en/in_word_end    byte writer side
//   in_ready                       current write bank can take data
//   err_overflow                   sticky: byte dropped, word too long
//   bank_din/bank_wr_addr          shared write bus to both banks
//   bankN_wr_en/bankN_set_full     per-bank write strobe / close pulse
//   bankN_full                     per-bank full flag
//   bank_rd_addr/bankN_dout        shared asynchronous read port
//   bankN_set_empty                per-bank release pulse (held in reset)
//   out_dout/out_valid/out_last/out_nul/out_rd_en  word stream output
// ---------------------------------------------------------------------------
module word_storage_pingpong_ctrl #(
  parameter int unsigned WORD_MAX_LEN = 16,
  localparam int unsigned AW = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1,
  localparam int unsigned CW = $clog2(WORD_MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [7:0]    in_din,
  input  logic          in_wr_en,
  input  logic          in_word_end,
  output logic          in_ready,
  output logic          err_overflow,
  output logic [7:0]    bank_din,
  output logic [AW-1:0] bank_wr_addr,
  output logic          bank0_wr_en,
  output logic          bank1_wr_en,
  output logic          bank0_set_full,
  output logic          bank1_set_full,
  input  logic          bank0_full,
  input  logic          bank1_full,
  output logic [AW-1:0] bank_rd_addr,
  input  logic [7:0]    bank0_dout,
  input  logic [7:0]    bank1_dout,
  output logic          bank0_set_empty,
  output logic          bank1_set_empty,
  output logic [7:0]    out_dout,
  output logic          out_valid,
  output logic          out_last,
  output logic          out_nul,
  input  logic          out_rd_en
);

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rd_state_t;

  // Write side state
  logic          wr_sel;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] len0;
  logic [CW-1:0] len1;
  logic          err_q;

  // Read side state
  rd_state_t     rd_state;
  rd_state_t     rd_state_next;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;

  // Combinational helpers
  logic          wr_bank_full;
  logic          wr_ok;
  logic          byte_acc;
  logic          byte_fits;
  logic          do_write;
  logic          do_close;
  logic [CW-1:0] wcnt_final;
  logic          rd_bank_full;
  logic [CW-1:0] rd_len;
  logic [7:0]    rd_dout;
  logic          rd_nul;
  logic          rd_last;
  logic          sending;
  logic          beat_acc;
  logic          drain;

  // Write-side decode
  always_comb begin
    wr_bank_full = wr_sel ? bank1_full : bank0_full;
    wr_ok        = ~rst & ~wr_bank_full;
    byte_acc     = in_wr_en & wr_ok;
    byte_fits    = (wcnt < CW'(WORD_MAX_LEN));
    do_write     = byte_acc & byte_fits;
    do_close     = in_word_end & wr_ok;
    // Length recorded on close includes a byte written in the same cycle;
    // byte_fits keeps it from exceeding WORD_MAX_LEN.
    wcnt_final   = do_write ? (wcnt + CW'(1)) : wcnt;
  end

  // Read-side decode and next state
  always_comb begin
    rd_bank_full  = rd_sel ? bank1_full : bank0_full;
    rd_len        = rd_sel ? len1 : len0;
    rd_dout       = rd_sel ? bank1_dout : bank0_dout;
    rd_nul        = (rd_len == '0);
    rd_last       = rd_nul | (CW'(rd_addr) == (rd_len - CW'(1)));
    sending       = (rd_state == R_SEND) & ~rst;
    beat_acc      = sending & out_rd_en;
    drain         = beat_acc & rd_last;
    rd_state_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (rd_bank_full) rd_state_next = R_SEND;
      R_SEND:  if (drain)        rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Outputs; everything is held at 0 in reset except the set_empty pulses,
  // which force both banks back to the write state.
  always_comb begin
    in_ready        = wr_ok;
    err_overflow    = err_q & ~rst;
    bank_din        = rst ? '0 : in_din;
    bank_wr_addr    = rst ? '0 : wcnt[AW-1:0];
    bank0_wr_en     = do_write & ~wr_sel;
    bank1_wr_en     = do_write &  wr_sel;
    bank0_set_full  = do_close & ~wr_sel;
    bank1_set_full  = do_close &  wr_sel;
    bank_rd_addr    = rst ? '0 : rd_addr;
    bank0_set_empty = rst | (drain & ~rd_sel);
    bank1_set_empty = rst | (drain &  rd_sel);
    out_valid       = sending;
    out_dout        = (sending & ~rd_nul) ? rd_dout : '0;
    out_last        = sending & rd_last;
    out_nul         = sending & rd_nul;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_sel   <= 1'b0;
      wcnt     <= '0;
      len0     <= '0;
      len1     <= '0;
      err_q    <= 1'b0;
      rd_state <= R_IDLE;
      rd_sel   <= 1'b0;
      rd_addr  <= '0;
    end else begin
      if (do_close) begin
        wcnt   <= '0;
        wr_sel <= ~wr_sel;
        if (wr_sel) len1 <= wcnt_final;
        else        len0 <= wcnt_final;
      end else if (do_write) begin
        wcnt <= wcnt + CW'(1);
      end

      if (byte_acc & ~byte_fits)
        err_q <= 1'b1;

      rd_state <= rd_state_next;
      if (rd_state == R_IDLE)
        rd_addr <= '0;
      else if (beat_acc & ~rd_last)
        rd_addr <= rd_addr + AW'(1);

      if (drain)
        rd_sel <= ~rd_sel;
    end
  end

endmodule

// File: tb/tb_word_storage_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for word_storage_pingpong_ctrl with WORD_MAX_LEN=4. Two simple
// word_storage stand-ins (memory + full flag) sit behind the DUT; a word-level
// model (queue of closed words, byte queue, pointer parity) predicts every
// cycle's outputs.
// ---------------------------------------------------------------------------
module tb_word_storage_pingpong_ctrl;

  localparam int WML = 4;
  localparam int AW  = 2;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_din = '0;
  logic          in_wr_en = 1'b0;
  logic          in_word_end = 1'b0;
  logic          in_ready;
  logic          err_overflow;
  logic [7:0]    bank_din;
  logic [AW-1:0] bank_wr_addr;
  logic          bank0_wr_en, bank1_wr_en;
  logic          bank0_set_full, bank1_set_full;
  logic          bank0_full = 1'b0, bank1_full = 1'b0;
  logic [AW-1:0] bank_rd_addr;
  logic [7:0]    bank0_dout, bank1_dout;
  logic          bank0_set_empty, bank1_set_empty;
  logic [7:0]    out_dout;
  logic          out_valid, out_last, out_nul;
  logic          out_rd_en = 1'b0;

  always #5 CLK = ~CLK;

  word_storage_pingpong_ctrl #(.WORD_MAX_LEN(WML)) dut (
    .CLK(CLK), .rst(rst),
    .in_din(in_din), .in_wr_en(in_wr_en), .in_word_end(in_word_end),
    .in_ready(in_ready), .err_overflow(err_overflow),
    .bank_din(bank_din), .bank_wr_addr(bank_wr_addr),
    .bank0_wr_en(bank0_wr_en), .bank1_wr_en(bank1_wr_en),
    .bank0_set_full(bank0_set_full), .bank1_set_full(bank1_set_full),
    .bank0_full(bank0_full), .bank1_full(bank1_full),
    .bank_rd_addr(bank_rd_addr),
    .bank0_dout(bank0_dout), .bank1_dout(bank1_dout),
    .bank0_set_empty(bank0_set_empty), .bank1_set_empty(bank1_set_empty),
    .out_dout(out_dout), .out_valid(out_valid), .out_last(out_last),
    .out_nul(out_nul), .out_rd_en(out_rd_en)
  );

  // Bank stand-ins
  logic [7:0] mem0 [0:WML-1];
  logic [7:0] mem1 [0:WML-1];
  initial for (int i = 0; i < WML; i++) begin mem0[i] = '0; mem1[i] = '0; end
  always @(posedge CLK) begin
    if (bank0_wr_en) mem0[bank_wr_addr] <= bank_din;
    if (bank1_wr_en) mem1[bank_wr_addr] <= bank_din;
    if (bank0_set_full)  bank0_full <= 1'b1;
    if (bank0_set_empty) bank0_full <= 1'b0;
    if (bank1_set_full)  bank1_full <= 1'b1;
    if (bank1_set_empty) bank1_full <= 1'b0;
  end
  assign bank0_dout = mem0[bank_rd_addr];
  assign bank1_dout = mem1[bank_rd_addr];

  // Counters
  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc_n, act, exp);
    end
  endtask

  // Word-level reference model
  logic [7:0] m_cur[$];    // bytes of the word being written
  logic [7:0] m_bytes[$];  // bytes of closed, not yet drained words, in order
  int         m_lens[$];   // lengths of closed, not yet drained words
  bit         m_sending = 0;
  int         m_beat    = 0;
  bit         m_err     = 0;
  bit         m_wpar    = 0;  // parity of words closed since reset
  bit         m_rpar    = 0;  // parity of words drained since reset

  typedef struct {
    bit         rst;
    logic [7:0] din;
    bit         we, wend, re;
    bit         chk;
    bit         x_ready, x_valid;
    logic [7:0] x_dout;
    bit         x_last, x_nul, x_err;
  } vec_t;

  function automatic vec_t V(bit r, logic [7:0] d, bit we, bit en, bit re,
                             bit ry, bit vl, logic [7:0] dt, bit ls, bit nl, bit er);
    vec_t v;
    v.rst = r; v.din = d; v.we = we; v.wend = en; v.re = re; v.chk = 1'b1;
    v.x_ready = ry; v.x_valid = vl; v.x_dout = dt; v.x_last = ls; v.x_nul = nl; v.x_err = er;
    return v;
  endfunction

  function automatic vec_t C(bit r, logic [7:0] d, bit we, bit en, bit re);
    vec_t v;
    v = V(r, d, we, en, re, 0, 0, 8'h00, 0, 0, 0);
    v.chk = 1'b0;
    return v;
  endfunction

  task automatic step(input vec_t v);
    bit e_ready, e_write, e_close, e_last, e_nul, e_drain, e_start;
    logic [7:0] e_dout;
    int len;
    e_ready = 0; e_write = 0; e_close = 0; e_last = 0; e_nul = 0;
    e_drain = 0; e_start = 0; e_dout = '0; len = 0;
    @(negedge CLK);
    rst = v.rst; in_din = v.din; in_wr_en = v.we; in_word_end = v.wend; out_rd_en = v.re;
    #1;
    cyc_n++;
    if (v.rst) begin
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_err", 32'(err_overflow), 0);
      chk("rst_set_empty", {30'd0, bank1_set_empty, bank0_set_empty}, 3);
      chk("rst_wr_en", {30'd0, bank1_wr_en, bank0_wr_en}, 0);
      chk("rst_set_full", {30'd0, bank1_set_full, bank0_set_full}, 0);
    end else begin
      e_ready = (m_lens.size() < 2);
      e_write = v.we && e_ready && (m_cur.size() < WML);
      e_close = v.wend && e_ready;
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("wr_en", {30'd0, bank1_wr_en, bank0_wr_en},
          {30'd0, e_write && m_wpar, e_write && !m_wpar});
      chk("set_full", {30'd0, bank1_set_full, bank0_set_full},
          {30'd0, e_close && m_wpar, e_close && !m_wpar});
      if (e_write) begin
        chk("wr_addr", 32'(bank_wr_addr), 32'(m_cur.size()));
        chk("bank_din", 32'(bank_din), 32'(v.din));
      end
      chk("err_overflow", 32'(err_overflow), 32'(m_err));
      chk("out_valid", 32'(out_valid), 32'(m_sending));
      if (m_sending) begin
        len    = m_lens[0];
        e_nul  = (len == 0);
        e_last = e_nul || (m_beat == len - 1);
        e_dout = e_nul ? 8'h00 : m_bytes[m_beat];
        chk("out_dout", 32'(out_dout), 32'(e_dout));
        chk("out_last", 32'(out_last), 32'(e_last));
        chk("out_nul", 32'(out_nul), 32'(e_nul));
        e_drain = v.re && e_last;
      end
      chk("set_empty", {30'd0, bank1_set_empty, bank0_set_empty},
          {30'd0, e_drain && m_rpar, e_drain && !m_rpar});
      e_start = !m_sending && (m_lens.size() > 0);
    end
    if (v.chk) begin
      chk("vec_ready", 32'(in_ready), 32'(v.x_ready));
      chk("vec_valid", 32'(out_valid), 32'(v.x_valid));
      chk("vec_err", 32'(err_overflow), 32'(v.x_err));
      if (v.x_valid) begin
        chk("vec_dout", 32'(out_dout), 32'(v.x_dout));
        chk("vec_last", 32'(out_last), 32'(v.x_last));
        chk("vec_nul", 32'(out_nul), 32'(v.x_nul));
      end
    end
    @(posedge CLK);
    if (v.rst) begin
      m_cur.delete(); m_bytes.delete(); m_lens.delete();
      m_sending = 0; m_beat = 0; m_err = 0; m_wpar = 0; m_rpar = 0;
    end else begin
      if (v.we && e_ready) begin
        if (m_cur.size() < WML) m_cur.push_back(v.din);
        else                    m_err = 1;
      end
      if (m_sending && v.re) begin
        if (e_last) begin
          repeat (len) void'(m_bytes.pop_front());
          void'(m_lens.pop_front());
          m_sending = 0;
          m_rpar = ~m_rpar;
        end else begin
          m_beat++;
        end
      end else if (e_start) begin
        m_sending = 1;
        m_beat = 0;
      end
      if (e_close) begin
        foreach (m_cur[i]) m_bytes.push_back(m_cur[i]);
        m_lens.push_back(m_cur.size());
        m_cur.delete();
        m_wpar = ~m_wpar;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    // Directed vectors: 'abc' word, zero-length word, overflowed word.
    tbl.push_back(V(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h61, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h62, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h63, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h61, 0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h62, 0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h63, 1, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h00, 1, 1, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(V(0, 8'(8'h11 + i), 1, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(V(0, 8'h16, 1, 0, 1, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h11, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h12, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h13, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 1, 8'h14, 1, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 1));
    foreach (tbl[i]) step(tbl[i]);

    // Both banks full with the reader stalled; third word is ignored.
    step(V(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    step(V(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    step(C(0, 8'hA1, 1, 0, 0));
    step(C(0, 8'hA2, 1, 1, 0));
    step(C(0, 8'hB1, 1, 1, 0));
    step(V(0, 8'hC1, 1, 0, 0, 0, 1, 8'hA1, 0, 0, 0));
    step(V(0, 8'hC2, 1, 1, 0, 0, 1, 8'hA1, 0, 0, 0));
    step(V(0, 8'h00, 0, 0, 1, 0, 1, 8'hA1, 0, 0, 0));
    step(V(0, 8'h00, 0, 0, 1, 0, 1, 8'hA2, 1, 0, 0));
    step(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    step(V(0, 8'h00, 0, 0, 1, 1, 1, 8'hB1, 1, 0, 0));
    step(V(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));

    // Write into one bank while the other streams with a stuttering reader.
    for (int i = 0; i < 4; i++) step(C(0, 8'(8'h30 + i), 1, i == 3, 0));
    for (int i = 0; i < 12; i++) step(C(0, 8'(8'h40 + i), i < 3, i == 2, i % 2));
    repeat (12) step(C(0, 8'h00, 0, 0, 1));

    // Reset mid-stream with both banks holding words.
    step(C(0, 8'h51, 1, 0, 0));
    step(C(0, 8'h52, 1, 1, 0));
    step(C(0, 8'h53, 1, 1, 0));
    step(C(0, 8'h00, 0, 0, 0));
    step(C(0, 8'h00, 0, 0, 1));
    step(V(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    step(V(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    step(V(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0));
    step(C(0, 8'h77, 1, 1, 1));
    repeat (4) step(C(0, 8'h00, 0, 0, 1));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      v = C($urandom_range(299) == 0, 8'($urandom), $urandom_range(2) != 0,
            $urandom_range(5) == 0, $urandom_range(2) != 0);
      step(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
